midi_learn_front: RTL and testbench

// Input front-end of the MIDI controller. Contains three parts:
//   - a 31250-baud 8N1 MIDI receiver that assembles complete channel messages;
//   - debouncing and press detection for three footswitches;
//   - a "learn" state machine: a press right after a received message saves that

---
 rtl/midi_learn_front_if.sv | 40 ++++
 rtl/midi_learn_front.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_midi_learn_front.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/midi_learn_front_if.sv
// MIDI learn front-end bundle: serial MIDI in, raw footswitches,
// captured message and button/learn outputs.
interface midi_learn_front_if;
    logic       midi_rx;
    logic [2:0] btn_raw;
    logic       cmd_valid;
    logic [7:0] status;
    logic [7:0] data1;
    logic [7:0] data2;
    logic [1:0] bytes_cnt;
    logic [1:0] btn_index;
    logic       save_mode;
    logic [1:0] learn_state;

    modport master (
        output midi_rx,
        output btn_raw,
        input  cmd_valid,
        input  status,
        input  data1,
        input  data2,
        input  bytes_cnt,
        input  btn_index,
        input  save_mode,
        input  learn_state
    );

    modport slave (
        input  midi_rx,
        input  btn_raw,
        output cmd_valid,
        output status,
        output data1,
        output data2,
        output bytes_cnt,
        output btn_index,
        output save_mode,
        output learn_state
    );
endinterface

// File: rtl/midi_learn_front.sv
// MIDI controller input front-end: 8N1 receiver, channel message
// parser, footswitch debounce and the learn/play press logic.
module midi_learn_front #(
    parameter int BAUD_CNT     = 3200,
    parameter int DEBOUNCE_CNT = 21
) (
    input  logic               clk,
    input  logic               rst,
    midi_learn_front_if.slave  bus
);

    localparam int CW = $clog2(BAUD_CNT);
    localparam logic [CW-1:0] HALF = CW'(BAUD_CNT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(BAUD_CNT - 1);
    localparam logic [DEBOUNCE_CNT-1:0] DMAX = {DEBOUNCE_CNT{1'b1}};

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // ---------------- receiver ----------------
    logic            rx_s1_q;
    logic            rx_s2_q;
    logic            rx_prev_q;
    rx_state_e       rx_state_q;
    rx_state_e       rx_state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [2:0]      bit_q;
    logic [2:0]      bit_d;
    logic [7:0]      shift_q;
    logic [7:0]      shift_d;
    logic            byte_stb;
    logic            rx_fall;

    assign rx_fall = rx_prev_q & ~rx_s2_q;

    // Synchronize the serial line and keep the previous level for edge detect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= bus.midi_rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    // Receiver state, bit timer, bit index and shift register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
        end
    end

    // Receiver next state: centre-sample start, 8 data bits LSB first, stop
    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_stb   = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_state_d = RX_START;
                    cnt_d      = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF) begin
                    cnt_d      = '0;
                    bit_d      = '0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    shift_d = {rx_s2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL) begin
                    cnt_d      = '0;
                    rx_state_d = RX_IDLE;
                    byte_stb   = rx_s2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------- parser ----------------
    logic [1:0] need_q;
    logic [1:0] need_d;
    logic [1:0] got_q;
    logic [1:0] got_d;
    logic [7:0] status_q;
    logic [7:0] status_d;
    logic [7:0] d1_q;
    logic [7:0] d1_d;
    logic [7:0] d2_q;
    logic [7:0] d2_d;
    logic       cv_q;
    logic       cv_d;
    logic [1:0] bc_q;
    logic [1:0] bc_d;
    logic       st_acc;
    logic       msg_done;

    // Parser registers: open message, captured bytes and valid flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            need_q   <= '0;
            got_q    <= '0;
            status_q <= '0;
            d1_q     <= '0;
            d2_q     <= '0;
            cv_q     <= 1'b0;
            bc_q     <= '0;
        end else begin
            need_q   <= need_d;
            got_q    <= got_d;
            status_q <= status_d;
            d1_q     <= d1_d;
            d2_q     <= d2_d;
            cv_q     <= cv_d;
            bc_q     <= bc_d;
        end
    end

    // Parse each good byte; system bytes and orphan data are ignored
    always_comb begin
        need_d   = need_q;
        got_d    = got_q;
        status_d = status_q;
        d1_d     = d1_q;
        d2_d     = d2_q;
        cv_d     = cv_q;
        bc_d     = bc_q;
        st_acc   = 1'b0;
        msg_done = 1'b0;
        if (byte_stb) begin
            if (shift_q[7]) begin
                if (shift_q[7:4] != 4'hF) begin
                    st_acc   = 1'b1;
                    status_d = shift_q;
                    d1_d     = '0;
                    d2_d     = '0;
                    cv_d     = 1'b0;
                    got_d    = '0;
                    need_d   = (shift_q[7:5] == 3'b110) ? 2'd1 : 2'd2;
                end
            end else if (need_q != 2'd0) begin
                if (got_q == 2'd0) begin
                    d1_d = shift_q;
                end else begin
                    d2_d = shift_q;
                end
                got_d = got_q + 2'd1;
                if (got_q + 2'd1 == need_q) begin
                    msg_done = 1'b1;
                    cv_d     = 1'b1;
                    bc_d     = need_q + 2'd1;
                    need_d   = '0;
                end
            end
        end
    end

    // ---------------- debounce ----------------
    logic [2:0]              b_s1_q;
    logic [2:0]              b_s2_q;
    logic [2:0]              lvl_q;
    logic [2:0]              lvl_d;
    logic [2:0]              lvl_prev_q;
    logic [DEBOUNCE_CNT-1:0] dcnt_q [3];
    logic [DEBOUNCE_CNT-1:0] dcnt_d [3];
    logic [2:0]              fell;

    assign fell = lvl_prev_q & ~lvl_q;

    // Button synchronizers, debounced levels and their previous value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b_s1_q     <= 3'b111;
            b_s2_q     <= 3'b111;
            lvl_q      <= 3'b111;
            lvl_prev_q <= 3'b111;
            for (int i = 0; i < 3; i++) begin
                dcnt_q[i] <= '0;
            end
        end else begin
            b_s1_q     <= bus.btn_raw;
            b_s2_q     <= b_s1_q;
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_q;
            for (int i = 0; i < 3; i++) begin
                dcnt_q[i] <= dcnt_d[i];
            end
        end
    end

    // Count while input disagrees with the level; adopt it when saturated
    always_comb begin
        lvl_d = lvl_q;
        for (int i = 0; i < 3; i++) begin
            dcnt_d[i] = '0;
            if (b_s2_q[i] != lvl_q[i]) begin
                if (dcnt_q[i] == DMAX) begin
                    lvl_d[i] = b_s2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
                end
            end
        end
    end

    // ---------------- learn ----------------
    logic [1:0] learn_q;
    logic [1:0] learn_d;
    logic [1:0] idx;
    logic       press;

    assign press = |fell;

    // Learn state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            learn_q <= '0;
        end else begin
            learn_q <= learn_d;
        end
    end

    // Lowest pressed index wins; the first press after a message saves it
    always_comb begin
        idx = 2'd0;
        priority case (1'b1)
            fell[0]: idx = 2'd1;
            fell[1]: idx = 2'd2;
            fell[2]: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        learn_d = learn_q;
        if (press && learn_q == 2'd1) begin
            learn_d = 2'd2;
        end
        if (st_acc) begin
            learn_d = 2'd0;
        end
        if (msg_done) begin
            learn_d = 2'd1;
        end
    end

    assign bus.cmd_valid   = cv_q;
    assign bus.status      = status_q;
    assign bus.data1       = d1_q;
    assign bus.data2       = d2_q;
    assign bus.bytes_cnt   = bc_q;
    assign bus.btn_index   = idx;
    assign bus.save_mode   = press && (learn_q == 2'd1);
    assign bus.learn_state = learn_q;

endmodule

// File: tb/tb_midi_learn_front.sv
// Scoreboard bench for midi_learn_front: serial MIDI messages and
// footswitch presses, with expected messages/presses queued at send time.
module tb_midi_learn_front;

    localparam int BAUD = 16;
    localparam int DEB  = 4;

    typedef struct {
        logic [7:0] st;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [1:0] bc;
    } msg_t;

    typedef struct {
        logic [1:0] idx;
        logic       save;
    } btn_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    logic cv_prev;

    msg_t msg_q[$];
    btn_t btn_q[$];

    midi_learn_front_if ifc ();

    midi_learn_front #(
        .BAUD_CNT     (BAUD),
        .DEBOUNCE_CNT (DEB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        ifc.midi_rx = 1'b0;
        tick(BAUD);
        for (int i = 0; i < 8; i++) begin
            ifc.midi_rx = b[i];
            tick(BAUD);
        end
        ifc.midi_rx = stop_bit;
        tick(BAUD);
        ifc.midi_rx = 1'b1;
        tick(4);
    endtask

    task automatic send_msg(input logic [7:0] st, input logic [7:0] d1,
                            input logic [7:0] d2, input int nb);
        msg_t m;
        m.st = st;
        m.d1 = d1;
        m.d2 = (nb == 3) ? d2 : 8'h00;
        m.bc = 2'(nb);
        msg_q.push_back(m);
        send_byte(st, 1'b1);
        send_byte(d1, 1'b1);
        if (nb == 3) begin
            send_byte(d2, 1'b1);
        end
    endtask

    task automatic press(input logic [2:0] mask, input int hold,
                         input logic [1:0] idx, input logic save,
                         input logic expect_it);
        btn_t b;
        b.idx  = idx;
        b.save = save;
        if (expect_it) begin
            btn_q.push_back(b);
        end
        ifc.btn_raw = ~mask;
        tick(hold);
        ifc.btn_raw = 3'b111;
        tick(40);
    endtask

    // Output monitor: compare new messages and press pulses to the queues
    always @(negedge clk) begin
        if (rst) begin
            if (ifc.cmd_valid && !cv_prev) begin
                if (msg_q.size() == 0) begin
                    check("cmd_unexpected", 32'd1, 32'd0);
                end else begin
                    msg_t e;
                    e = msg_q.pop_front();
                    check("status", 32'(ifc.status), 32'(e.st));
                    check("data1", 32'(ifc.data1), 32'(e.d1));
                    check("data2", 32'(ifc.data2), 32'(e.d2));
                    check("bytes_cnt", 32'(ifc.bytes_cnt), 32'(e.bc));
                    check("learn_on_msg", 32'(ifc.learn_state), 32'd1);
                end
            end
            if (ifc.btn_index != 2'd0) begin
                if (btn_q.size() == 0) begin
                    check("btn_unexpected", 32'(ifc.btn_index), 32'd0);
                end else begin
                    btn_t e;
                    e = btn_q.pop_front();
                    check("btn_index", 32'(ifc.btn_index), 32'(e.idx));
                    check("save_mode", 32'(ifc.save_mode), 32'(e.save));
                end
            end else if (ifc.save_mode) begin
                check("save_idle", 32'(ifc.save_mode), 32'd0);
            end
        end
        cv_prev = ifc.cmd_valid;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        cv_prev     = 1'b0;
        rst         = 1'b0;
        ifc.midi_rx = 1'b1;
        ifc.btn_raw = 3'b111;
        tick(3);
        check("rst_cmd_valid", 32'(ifc.cmd_valid), 32'd0);
        check("rst_status", 32'(ifc.status), 32'd0);
        check("rst_btn_index", 32'(ifc.btn_index), 32'd0);
        check("rst_learn", 32'(ifc.learn_state), 32'd0);
        rst = 1'b1;
        tick(5);

        press(3'b001, 20, 2'd1, 1'b0, 1'b1);
        press(3'b100, 3, 2'd3, 1'b0, 1'b0);
        check("btn_pending_a", 32'(btn_q.size()), 32'd0);

        send_msg(8'hB0, 8'h2E, 8'h7F, 3);
        check("msg_pending_a", 32'(msg_q.size()), 32'd0);
        check("learn_pending", 32'(ifc.learn_state), 32'd1);

        press(3'b010, 20, 2'd2, 1'b1, 1'b1);
        check("learn_assigned", 32'(ifc.learn_state), 32'd2);
        press(3'b010, 20, 2'd2, 1'b0, 1'b1);
        check("learn_still_2", 32'(ifc.learn_state), 32'd2);

        send_msg(8'hC0, 8'h42, 8'h00, 2);
        send_byte(8'h2E, 1'b1);
        check("orphan_cv", 32'(ifc.cmd_valid), 32'd1);
        check("orphan_status", 32'(ifc.status), 32'hC0);
        check("orphan_d1", 32'(ifc.data1), 32'h42);
        check("orphan_d2", 32'(ifc.data2), 32'h00);
        check("orphan_bc", 32'(ifc.bytes_cnt), 32'd2);
        check("orphan_learn", 32'(ifc.learn_state), 32'd1);

        press(3'b101, 20, 2'd1, 1'b1, 1'b1);
        check("learn_multi", 32'(ifc.learn_state), 32'd2);
        check("btn_pending_b", 32'(btn_q.size()), 32'd0);

        ifc.midi_rx = 1'b0;
        tick(2);
        ifc.midi_rx = 1'b1;
        tick(6);
        send_msg(8'h90, 8'h3C, 8'h40, 3);

        send_byte(8'hF8, 1'b1);
        check("sys_ignored_cv", 32'(ifc.cmd_valid), 32'd1);
        check("sys_ignored_st", 32'(ifc.status), 32'h90);

        begin
            msg_t m;
            m.st = 8'hB0;
            m.d1 = 8'h2E;
            m.d2 = 8'h7F;
            m.bc = 2'd3;
            msg_q.push_back(m);
            send_byte(8'hB0, 1'b1);
            send_byte(8'h11, 1'b0);
            send_byte(8'h2E, 1'b1);
            send_byte(8'h7F, 1'b1);
        end
        check("msg_pending_b", 32'(msg_q.size()), 32'd0);

        ifc.midi_rx = 1'b0;
        tick(40);
        rst = 1'b0;
        #1;
        check("mid_rst_cv", 32'(ifc.cmd_valid), 32'd0);
        check("mid_rst_status", 32'(ifc.status), 32'd0);
        check("mid_rst_d1", 32'(ifc.data1), 32'd0);
        check("mid_rst_bc", 32'(ifc.bytes_cnt), 32'd0);
        check("mid_rst_learn", 32'(ifc.learn_state), 32'd0);
        ifc.midi_rx = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(5);
        send_msg(8'hE0, 8'h01, 8'h02, 3);

        tick(50);
        check("msg_left", 32'(msg_q.size()), 32'd0);
        check("btn_left", 32'(btn_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
